// File: rtl/cla_key_sched_ctrl.sv
// cla_key_sched_ctrl: key-locked adder controller with known-answer unlock and round-robin requester arbitration
module cla_key_sched_ctrl #(
  parameter logic [31:0] KAT_A   = 32'h89AB_CDEF,
  parameter logic [31:0] KAT_B   = 32'h7654_3211,
  parameter logic [32:0] KAT_SUM = 33'h1_0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        key_bit_i,
  input  logic        key_shift_i,
  input  logic [1:0]  req_valid_i,
  input  logic [31:0] req_a0_i,
  input  logic [31:0] req_b0_i,
  input  logic [31:0] req_a1_i,
  input  logic [31:0] req_b1_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  rsp_valid_o,
  output logic [32:0] rsp_sum_o,
  output logic [31:0] adder_a_o,
  output logic [31:0] adder_b_o,
  output logic [63:0] adder_key_o,
  input  logic [32:0] adder_sum_i,
  output logic        unlocked_o,
  output logic        kat_fail_o,
  output logic        busy_o
);
  typedef enum logic [2:0] {KEY_LOAD, KAT_DRIVE, KAT_CHECK, READY, EXEC, FAIL} state_e;
  state_e      state_q, state_d;
  logic [63:0] key_q, key_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        prio_q, prio_d, gidx_q, gidx_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [32:0] sum_q, sum_d;
  logic [1:0]  rsp_q, rsp_d, gnt;
  // grant, next-state and datapath updates; a key shift in READY pre-empts any grant
  always_comb begin
    gnt     = (state_q == READY && !key_shift_i) ?
              ((req_valid_i == 2'b11) ? (prio_q ? 2'b10 : 2'b01) : req_valid_i) : 2'b00;
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    gidx_d  = gidx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    rsp_d   = 2'b00;
    case (state_q)
      KEY_LOAD: if (key_shift_i) begin
        key_d   = {key_bit_i, key_q[63:1]};
        cnt_d   = cnt_q + 6'd1;
        state_d = (cnt_q == 6'd63) ? KAT_DRIVE : KEY_LOAD;
      end
      KAT_DRIVE: begin
        a_d     = KAT_A;
        b_d     = KAT_B;
        state_d = KAT_CHECK;
      end
      KAT_CHECK: state_d = (adder_sum_i == KAT_SUM) ? READY : FAIL;
      READY, FAIL: if (key_shift_i) begin
        key_d   = {key_bit_i, key_q[63:1]};
        cnt_d   = 6'd1;
        state_d = KEY_LOAD;
      end else if (gnt != 2'b00) begin
        a_d     = gnt[1] ? req_a1_i : req_a0_i;
        b_d     = gnt[1] ? req_b1_i : req_b0_i;
        gidx_d  = gnt[1];
        prio_d  = ~gnt[1];
        state_d = EXEC;
      end
      EXEC: begin
        sum_d   = adder_sum_i;
        rsp_d   = gidx_q ? 2'b10 : 2'b01;
        state_d = READY;
      end
      default: state_d = KEY_LOAD;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= KEY_LOAD;
      key_q   <= '0;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      gidx_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      gidx_q  <= gidx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      rsp_q   <= rsp_d;
    end
  end
  assign req_ready_o = gnt;
  assign rsp_valid_o = rsp_q;
  assign rsp_sum_o   = sum_q;
  assign adder_a_o   = a_q;
  assign adder_b_o   = b_q;
  assign adder_key_o = key_q;
  assign unlocked_o  = state_q == READY || state_q == EXEC;
  assign kat_fail_o  = state_q == FAIL;
  assign busy_o      = (state_q == KEY_LOAD && cnt_q != 6'd0) || state_q == KAT_DRIVE ||
                       state_q == KAT_CHECK || state_q == EXEC;
endmodule

// File: tb/tb_cla_key_sched_ctrl.sv
// tb_cla_key_sched_ctrl: randomized self-checking bench with a transaction-level reference model
module tb_cla_key_sched_ctrl;
  logic        clk = 0, rst_n = 0, key_bit = 0, key_shift = 0;
  logic [1:0]  req_valid = 0, req_ready, rsp_valid;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, adder_a, adder_b;
  logic [32:0] rsp_sum, adder_sum;
  logic [63:0] adder_key, secret;
  logic        unlocked, kat_fail, busy;
  int          n_chk = 0, n_pass = 0;
  logic        m_prio = 0;
  typedef struct {int due; logic [1:0] g; logic [32:0] s;} rsp_t;

  cla_key_sched_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .key_bit_i(key_bit), .key_shift_i(key_shift),
    .req_valid_i(req_valid), .req_a0_i(a0), .req_b0_i(b0), .req_a1_i(a1), .req_b1_i(b1),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_sum_o(rsp_sum),
    .adder_a_o(adder_a), .adder_b_o(adder_b), .adder_key_o(adder_key),
    .adder_sum_i(adder_sum), .unlocked_o(unlocked), .kat_fail_o(kat_fail), .busy_o(busy)
  );

  // external key-locked adder: correct sum only under the secret key
  assign adder_sum = (adder_key == secret) ? {1'b0, adder_a} + {1'b0, adder_b} : 33'h0_FFFF_FFFF;

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_chk++; if ({req_ready, rsp_valid} !== 4'b0) $display("FAIL rst_hs got %b exp 0000", {req_ready, rsp_valid}); else n_pass++;
    n_chk++; if ({unlocked, kat_fail, busy} !== 3'b0) $display("FAIL rst_flags got %b exp 000", {unlocked, kat_fail, busy}); else n_pass++;
    n_chk++; if ({adder_a, adder_b, rsp_sum, adder_key} !== '0) $display("FAIL rst_data got nonzero exp 0"); else n_pass++;
    tick;
    rst_n = 1;
    tick;
    n_chk++; if ({unlocked, busy, req_ready} !== 4'b0) $display("FAIL rst_idle got %b exp 0000", {unlocked, busy, req_ready}); else n_pass++;
  endtask

  task automatic load_key(input logic [63:0] k, input logic [1:0] vld, input logic good);
    req_valid = vld;
    for (int i = 0; i < 64; i++) begin
      key_bit = k[i];
      key_shift = 1;
      #1;
      n_chk++; if (req_ready !== 2'b00) $display("FAIL load_ready bit %0d got %b exp 00", i, req_ready); else n_pass++;
      tick;
      if (i == 0) begin
        n_chk++; if ({unlocked, kat_fail, busy} !== 3'b001) $display("FAIL load_first got %b exp 001", {unlocked, kat_fail, busy}); else n_pass++;
      end
    end
    key_shift = 0;
    n_chk++; if (adder_key !== k) $display("FAIL load_key got %h exp %h", adder_key, k); else n_pass++;
    tick;
    req_valid = 0;
    n_chk++; if ({unlocked, kat_fail, busy} !== 3'b001) $display("FAIL load_check got %b exp 001", {unlocked, kat_fail, busy}); else n_pass++;
    tick;
    n_chk++; if ({unlocked, kat_fail, busy} !== {good, ~good, 1'b0}) $display("FAIL load_done got %b exp %b", {unlocked, kat_fail, busy}, {good, ~good, 1'b0}); else n_pass++;
  endtask

  task automatic test_fail_hold;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if ({req_ready, kat_fail} !== 3'b001) $display("FAIL fail_hold got %b exp 001", {req_ready, kat_fail}); else n_pass++;
      tick;
    end
    req_valid = 0;
  endtask

  task automatic test_carry;
    req_valid = 2'b01; a0 = 32'hFFFF_FFFF; b0 = 32'h1; a1 = $urandom; b1 = $urandom;
    #1;
    n_chk++; if (req_ready !== 2'b01) $display("FAIL carry_ready got %b exp 01", req_ready); else n_pass++;
    tick;
    req_valid = 0; key_shift = 1; key_bit = 1;
    #1;
    n_chk++; if ({busy, rsp_valid} !== 3'b100) $display("FAIL carry_exec got %b exp 100", {busy, rsp_valid}); else n_pass++;
    n_chk++; if ({adder_a, adder_b} !== {32'hFFFF_FFFF, 32'h1}) $display("FAIL carry_ops got %h exp ffffffff00000001", {adder_a, adder_b}); else n_pass++;
    tick;
    key_shift = 0;
    n_chk++; if ({rsp_valid, unlocked} !== 3'b011) $display("FAIL carry_rsp got %b exp 011", {rsp_valid, unlocked}); else n_pass++;
    n_chk++; if (rsp_sum !== 33'h1_0000_0000) $display("FAIL carry_sum got %h exp 100000000", rsp_sum); else n_pass++;
    tick;
    n_chk++; if ({rsp_valid, busy} !== 3'b000) $display("FAIL carry_after got %b exp 000", {rsp_valid, busy}); else n_pass++;
    n_chk++; if (rsp_sum !== 33'h1_0000_0000) $display("FAIL carry_hold got %h exp 100000000", rsp_sum); else n_pass++;
    m_prio = 1;
  endtask

  task automatic test_back_to_back;
    logic [1:0] eg [10];
    logic [32:0] es [10];
    req_valid = 2'b10; a1 = $urandom; b1 = $urandom;
    #1;
    n_chk++; if (req_ready !== 2'b10) $display("FAIL b2b_prime got %b exp 10", req_ready); else n_pass++;
    tick;
    req_valid = 0;
    tick;
    tick;
    for (int i = 0; i < 10; i++) begin
      req_valid = (i < 8) ? 2'b11 : 2'b00;
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      #1;
      eg[i] = (i < 8 && i % 2 == 0) ? ((i % 4 == 0) ? 2'b01 : 2'b10) : 2'b00;
      es[i] = eg[i][1] ? {1'b0, a1} + {1'b0, b1} : {1'b0, a0} + {1'b0, b0};
      n_chk++; if (req_ready !== eg[i]) $display("FAIL b2b_grant cyc %0d got %b exp %b", i, req_ready, eg[i]); else n_pass++;
      if (i >= 2 && eg[i-2] != 2'b00) begin
        n_chk++; if (rsp_valid !== eg[i-2]) $display("FAIL b2b_rsp cyc %0d got %b exp %b", i, rsp_valid, eg[i-2]); else n_pass++;
        n_chk++; if (rsp_sum !== es[i-2]) $display("FAIL b2b_sum cyc %0d got %h exp %h", i, rsp_sum, es[i-2]); else n_pass++;
      end
      tick;
    end
    m_prio = 0;
  endtask

  task automatic test_random(input int n);
    rsp_t q[$];
    rsp_t e;
    int cool = 0;
    logic [1:0] v, eg;
    for (int c = 0; c < n + 2; c++) begin
      v = (c < n) ? 2'($urandom_range(0, 3)) : 2'b00;
      req_valid = v; a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      #1;
      eg = (cool != 0) ? 2'b00 : (v == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : v;
      n_chk++; if (req_ready !== eg) $display("FAIL rnd_grant cyc %0d got %b exp %b", c, req_ready, eg); else n_pass++;
      if (q.size() > 0 && q[0].due == c) begin
        e = q.pop_front();
        n_chk++; if (rsp_valid !== e.g) $display("FAIL rnd_rsp cyc %0d got %b exp %b", c, rsp_valid, e.g); else n_pass++;
        n_chk++; if (rsp_sum !== e.s) $display("FAIL rnd_sum cyc %0d got %h exp %h", c, rsp_sum, e.s); else n_pass++;
      end else begin
        n_chk++; if (rsp_valid !== 2'b00) $display("FAIL rnd_idle cyc %0d got %b exp 00", c, rsp_valid); else n_pass++;
      end
      cool = 0;
      if (eg != 2'b00) begin
        q.push_back('{c + 2, eg, eg[1] ? {1'b0, a1} + {1'b0, b1} : {1'b0, a0} + {1'b0, b0}});
        m_prio = eg[0];
        cool = 1;
      end
      tick;
    end
    req_valid = 0;
  endtask

  task automatic test_reset_exec;
    req_valid = 2'b10; a1 = $urandom; b1 = $urandom;
    tick;
    req_valid = 0;
    #2;
    rst_n = 0;
    #1;
    n_chk++; if ({req_ready, rsp_valid, unlocked, kat_fail, busy} !== 7'b0) $display("FAIL rexec_flags got %b exp 0", {req_ready, rsp_valid, unlocked, kat_fail, busy}); else n_pass++;
    n_chk++; if ({adder_a, adder_b, rsp_sum, adder_key} !== '0) $display("FAIL rexec_data got nonzero exp 0"); else n_pass++;
    tick;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_chk++; if ({rsp_valid, unlocked, busy} !== 4'b0) $display("FAIL rexec_after cyc %0d got %b exp 0000", i, {rsp_valid, unlocked, busy}); else n_pass++;
    end
  endtask

  initial begin
    secret = {$urandom, $urandom};
    test_reset;
    load_key(~secret, 2'b11, 1'b0);
    test_fail_hold;
    load_key(secret, 2'b00, 1'b1);
    test_carry;
    test_back_to_back;
    test_random(60);
    load_key(secret, 2'b11, 1'b1);
    test_reset_exec;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
